dds_freq_meter: RTL and testbench

Measurement front end for the DDS sample stream. It takes the 10-bit offset-binary samples the DDS drives toward the DAC and recovers the waveform period over a programmable number of cycles, plus the peak and trough amplitude. It uses a hysteretic midscale-crossing detector and a cycle counter. It sits on the DDS output bus as an in-system checker and loop-back monitor for Fword/Pword programming.

---
 rtl/dds_freq_meter_if.sv | 26 ++
 rtl/dds_freq_meter.sv | 159 +++++++++++++++
 tb/tb_dds_freq_meter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_freq_meter_if.sv
// Sample/control/result bundle between the DDS output bus and the frequency meter.
interface dds_freq_meter_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              start;
  logic              cont;
  logic              busy;
  logic              meas_valid;
  logic [CNT_W-1:0]  period_cnt;
  logic [DATA_W-1:0] peak_max;
  logic [DATA_W-1:0] peak_min;
  logic              timeout;

  modport master (
    output sample_in, sample_valid, start, cont,
    input  busy, meas_valid, period_cnt, peak_max, peak_min, timeout
  );

  modport slave (
    input  sample_in, sample_valid, start, cont,
    output busy, meas_valid, period_cnt, peak_max, peak_min, timeout
  );
endinterface

// File: rtl/dds_freq_meter.sv
// Period and peak/trough meter for the DDS sample stream: hysteretic midscale
// crossing detector feeding an NPER-period window counter.
module dds_freq_meter #(
  parameter int DATA_W  = 10,
  parameter int MID     = 512,
  parameter int HYST    = 16,
  parameter int NPER    = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1 << 24
) (
  input  logic           clk,
  input  logic           reset,
  dds_freq_meter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, MEAS, DONE} state_t;

  localparam int                      XC_W    = $clog2(NPER) + 1;
  localparam logic [XC_W-1:0]         X_LAST  = XC_W'(NPER - 1);
  localparam logic [CNT_W-1:0]        TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [DATA_W:0]  HYST_S  = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0]  MID_S   = (DATA_W+1)'(MID);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic signed [DATA_W:0] center(input logic [DATA_W-1:0] s);
    return $signed({1'b0, s}) - MID_S;
  endfunction

  logic signed [DATA_W:0] ctr_p0;
  logic                   set_p0, clr_p0;
  logic                   hi_p1, xr_p1;
  state_t                 state, state_nx;
  logic                   to_cond, to_hit, sync_hit, fin_hit;
  logic [CNT_W-1:0]       cnt;
  logic [XC_W-1:0]        xcnt;
  logic [DATA_W-1:0]      pmax_r, pmin_r;
  logic                   meas_valid_r, timeout_r;
  logic [CNT_W-1:0]       period_r;
  logic [DATA_W-1:0]      peak_max_r, peak_min_r;

  // stage p0: signed distance of the sample from midscale
  assign ctr_p0 = center(bus.sample_in);
  assign set_p0 = bus.sample_valid && (ctr_p0 >= HYST_S);
  assign clr_p0 = bus.sample_valid && (ctr_p0 <= -HYST_S);

  // stage p1: Schmitt state and registered rising-crossing pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_p1 <= 1'b0;
      xr_p1 <= 1'b0;
    end else begin
      xr_p1 <= set_p0 && !hi_p1;
      if (set_p0)
        hi_p1 <= 1'b1;
      else if (clr_p0)
        hi_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  assign to_cond = (cnt == TO_LAST);

  // Timeout is tested before any crossing so an abort always wins.
  always_comb begin
    state_nx = state;
    to_hit   = 1'b0;
    sync_hit = 1'b0;
    fin_hit  = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_nx = ARM;
      ARM: begin
        if (to_cond) begin
          to_hit   = 1'b1;
          state_nx = IDLE;
        end else if (!hi_p1) begin
          state_nx = SYNC;
        end
      end
      SYNC: begin
        if (to_cond) begin
          to_hit   = 1'b1;
          state_nx = IDLE;
        end else if (xr_p1) begin
          sync_hit = 1'b1;
          state_nx = MEAS;
        end
      end
      MEAS: begin
        if (to_cond) begin
          to_hit   = 1'b1;
          state_nx = IDLE;
        end else if (xr_p1 && xcnt == X_LAST) begin
          fin_hit  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = bus.cont ? MEAS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window datapath: the closing crossing reopens the window, so a continuous
  // run restarts from the same edge without losing a period.
  always_ff @(posedge clk) begin
    if (state == IDLE || sync_hit || fin_hit)
      cnt <= '0;
    else
      cnt <= sat_inc(cnt);

    if (sync_hit || fin_hit)
      xcnt <= '0;
    else if (state == MEAS && xr_p1)
      xcnt <= xcnt + 1'b1;

    if (sync_hit || fin_hit) begin
      pmax_r <= bus.sample_in;
      pmin_r <= bus.sample_in;
    end else if ((state == MEAS || state == DONE) && bus.sample_valid) begin
      if (bus.sample_in > pmax_r) pmax_r <= bus.sample_in;
      if (bus.sample_in < pmin_r) pmin_r <= bus.sample_in;
    end
  end

  // Result registers: the cnt seen at the closing crossing is one short of tN - t0.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_valid_r <= 1'b0;
      timeout_r    <= 1'b0;
      period_r     <= '0;
      peak_max_r   <= '0;
      peak_min_r   <= '1;
    end else begin
      meas_valid_r <= fin_hit;
      timeout_r    <= to_hit;
      if (fin_hit) begin
        period_r   <= sat_inc(cnt);
        peak_max_r <= (bus.sample_valid && bus.sample_in > pmax_r) ? bus.sample_in : pmax_r;
        peak_min_r <= (bus.sample_valid && bus.sample_in < pmin_r) ? bus.sample_in : pmin_r;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.meas_valid = meas_valid_r;
  assign bus.timeout    = timeout_r;
  assign bus.period_cnt = period_r;
  assign bus.peak_max   = peak_max_r;
  assign bus.peak_min   = peak_min_r;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Scoreboard bench for dds_freq_meter: a sinewave DDS model feeds the meter and
// expected windows are derived from the generated sample list.
module tb_dds_freq_meter;
  localparam int DATA_W  = 10;
  localparam int MID     = 512;
  localparam int HYST    = 16;
  localparam int NPER    = 16;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dds_freq_meter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dds_freq_meter #(
    .DATA_W(DATA_W), .MID(MID), .HYST(HYST), .NPER(NPER),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int slot;
    int period;
    int pmax;
    int pmin;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  exp_t e_mon;
  int   total = 0;
  int   bad = 0;
  int   to_slot = -1;
  bit   to_seen = 1'b0;
  bit   expect_to = 1'b0;
  int   samp[$];
  bit   vld[$];
  int   xs[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.meas_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_meas_valid", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("meas_valid_slot", cyc, e_mon.slot);
          check("period_cnt", bus.period_cnt, e_mon.period);
          check("peak_max", bus.peak_max, e_mon.pmax);
          check("peak_min", bus.peak_min, e_mon.pmin);
        end
      end
      if (bus.timeout) begin
        check("timeout_slot", cyc, to_slot);
        to_seen = 1'b1;
      end
    end
  end

  function automatic int wave(input logic [31:0] ph);
    real r;
    int  v;
    r = 511.5 + 511.5 * $sin(6.283185307179586 * real'(ph) / 4294967296.0);
    v = int'(r);
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // Sample list: low preamble, then the DDS waveform; rising crossings are the
  // valid samples that reach MID+HYST after the last valid one at or below MID-HYST.
  task automatic build_run(input logic [31:0] f, input logic [31:0] p, input bit tog,
                           input bit noisy, input int ncross);
    logic [31:0] ph;
    bit          hi;
    int          s;
    int          n;
    bit          v;
    ph = p;
    hi = 1'b0;
    n  = 0;
    samp.delete(); vld.delete(); xs.delete();
    for (int k = 0; k < 8; k++) begin
      samp.push_back(0);
      vld.push_back(1'b1);
    end
    while ((xs.size() < ncross || n < 0) && samp.size() < 30000) begin
      s = wave(ph);
      if (noisy) s = s + int'($urandom_range(20, 0)) - 10;
      if (s < 0) s = 0;
      if (s > 1023) s = 1023;
      v = tog ? (n % 2 == 0) : 1'b1;
      samp.push_back(s);
      vld.push_back(v);
      if (v) begin
        if (s >= MID + HYST && !hi) begin
          hi = 1'b1;
          xs.push_back(samp.size() - 1);
        end else if (s <= MID - HYST) begin
          hi = 1'b0;
        end
      end
      ph = ph + f;
      n++;
    end
    for (int k = 0; k < 8; k++) begin
      samp.push_back(wave(ph));
      vld.push_back(1'b1);
      ph = ph + f;
    end
  endtask

  task automatic push_windows(input int base, input int nwin);
    exp_t e;
    int   k0;
    int   kn;
    for (int j = 0; j < nwin; j++) begin
      k0 = xs[NPER*j];
      kn = xs[NPER*(j+1)];
      e.period = kn - k0;
      e.slot   = base + kn + 2;
      e.pmax   = samp[k0+1];
      e.pmin   = samp[k0+1];
      for (int i = k0 + 2; i <= kn + 1; i++) begin
        if (vld[i]) begin
          if (samp[i] > e.pmax) e.pmax = samp[i];
          if (samp[i] < e.pmin) e.pmin = samp[i];
        end
      end
      exp_q.push_back(e);
      last_e = e;
    end
  endtask

  task automatic drive(input int nwin, input int cont_drop, input bit spam, input int rst_at);
    int base;
    base = 0;
    for (int i = 0; i < samp.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        base = cyc;
        if (rst_at < 0) push_windows(base, nwin);
        if (expect_to) to_slot = base + TIMEOUT + 3;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        reset = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_meas_valid", bus.meas_valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_period_cnt", bus.period_cnt, 0);
        check("rst_peak_max", bus.peak_max, 0);
        check("rst_peak_min", bus.peak_min, 1023);
        break;
      end
      bus.sample_in    = DATA_W'(samp[i]);
      bus.sample_valid = vld[i];
      bus.start        = (i == 2) || (spam && i > 3 && (i % 7) == 0 && bus.busy);
      bus.cont         = (i < cont_drop);
      if (i == rst_at) reset = 1'b1;
    end
    bus.start = 1'b0;
    bus.cont  = 1'b0;
    @(negedge clk);
    check("busy_after_run", bus.busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic run(input logic [31:0] f, input logic [31:0] p, input bit tog,
                     input bit noisy, input bit spam, input int nwin, input bit cont);
    int cont_drop;
    build_run(f, p, tog, noisy, NPER * nwin + 1);
    if (xs.size() < NPER * nwin + 1) begin
      check("crossings_generated", xs.size(), NPER * nwin + 1);
    end else begin
      cont_drop = cont ? xs[NPER*(nwin-1)] + 10 : 0;
      drive(nwin, cont_drop, spam, -1);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.start        = 1'b0;
    bus.cont         = 1'b0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_meas_valid", bus.meas_valid, 0);
    check("reset_timeout", bus.timeout, 0);
    check("reset_period_cnt", bus.period_cnt, 0);
    check("reset_peak_max", bus.peak_max, 0);
    check("reset_peak_min", bus.peak_min, 1023);
    reset = 1'b0;
    @(negedge clk);

    // single windows: Fword 2^26 at two phase offsets, then random Fwords/phases
    run(32'h0400_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    run(32'h0400_0000, 32'd512 << 22, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    for (int k = 0; k < 3; k++)
      run($urandom_range(32'h0800_0000, 32'h0200_0000), $urandom, 1'b0, 1'b0, 1'b0, 1, 1'b0);

    // continuous: cont dropped inside the sixth window
    run(32'h0400_0000, 32'h0, 1'b0, 1'b0, 1'b0, 6, 1'b1);

    // midscale noise, then 50% sample_valid with repeated start while busy
    run($urandom_range(32'h0800_0000, 32'h0200_0000), $urandom, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    run(32'h0400_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1, 1'b0);

    // flat midscale input aborts after TIMEOUT clocks and leaves results alone
    samp.delete(); vld.delete();
    for (int k = 0; k < TIMEOUT + 20; k++) begin
      samp.push_back(MID);
      vld.push_back(1'b1);
    end
    to_seen   = 1'b0;
    expect_to = 1'b1;
    drive(0, 0, 1'b0, -1);
    expect_to = 1'b0;
    to_slot   = -1;
    check("timeout_seen", to_seen, 1);
    check("hold_period_cnt", bus.period_cnt, last_e.period);
    check("hold_peak_max", bus.peak_max, last_e.pmax);
    check("hold_peak_min", bus.peak_min, last_e.pmin);

    // reset in the middle of a measurement window
    build_run(32'h0400_0000, 32'h0, 1'b0, 1'b0, NPER + 1);
    drive(1, 0, 1'b0, 300);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
